// File: rtl/muldiv_pkg.sv
// Shared constants and types for the RV32M multiply/divide sequencer.
// The optional single-cycle multiply is enabled by defining MULDIV_FAST_MUL_EN.
package muldiv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_t;

  // rs1 is treated as signed for everything except the fully unsigned ops.
  function automatic logic rs1_signed(input logic [2:0] f3);
    return (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
  endfunction

  // rs2 is signed only for MUL, MULH, DIV and REM.
  function automatic logic rs2_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_core.sv
// Iterative datapath: shift-add multiply and restoring divide share the
// hi/lo register pair. Operands arrive as magnitudes; signs are fixed on output.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] a_mag,
  input  logic [XLEN-1:0] b_mag,
  input  logic            res_neg,
  input  logic            rem_neg,
  output logic [XLEN-1:0] result
);

  // hi: upper product half / remainder; lo: multiplier+low product / dividend+quotient
  logic [XLEN-1:0] hi_q, lo_q, b_q;
  logic [2:0]      f3_q;
  logic            res_neg_q, rem_neg_q;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] prod_mag, prod;
  logic [XLEN-1:0]   quo, rem;

  // One add/shift and one subtract/shift candidate per cycle.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, b_q};
  end

  // Operand capture and iteration registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q      <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      f3_q      <= '0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else if (load) begin
      hi_q      <= '0;
      lo_q      <= a_mag;
      b_q       <= b_mag;
      f3_q      <= func3;
      res_neg_q <= res_neg;
      rem_neg_q <= rem_neg;
    end else if (step) begin
      if (f3_q[2]) begin
        if (!div_diff[XLEN+1]) begin
          hi_q <= div_diff[XLEN-1:0];
          lo_q <= {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_q <= div_shift[XLEN-1:0];
          lo_q <= {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        hi_q <= mul_sum[XLEN:1];
        lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  // Sign fix and result selection.
  always_comb begin
    prod_mag = {hi_q, lo_q};
    prod     = res_neg_q ? -prod_mag : prod_mag;
    quo      = res_neg_q ? -lo_q : lo_q;
    rem      = rem_neg_q ? -hi_q : hi_q;
    if (f3_q[2])
      result = f3_q[1] ? rem : quo;
    else if (f3_q == F3_MUL)
      result = prod[XLEN-1:0];
    else
      result = prod[2*XLEN-1:XLEN];
  end

endmodule

// File: rtl/ex_muldiv_seq.sv
// RV32M sequencer beside EX: detects M ops, stalls the pipeline while the
// shared datapath iterates, then presents a one-cycle result.
// Define MULDIV_FAST_MUL_EN to resolve multiplies in a single cycle.
// Handshake: stall is high while an M op in EX cannot yet retire; the cycle
// with md_valid=1 has stall=0 and the pipeline advances on that edge.
module ex_muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [6:0]      ex_opcode,
  input  logic [2:0]      ex_func3,
  input  logic [6:0]      ex_func7,
  input  logic [4:0]      ex_rd_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            kill,
  output logic            stall,
  output logic            busy,
  output logic            md_valid,
  output logic [XLEN-1:0] md_result,
  output logic [4:0]      md_rd_addr
);

  md_state_t       state_q, state_d;
  logic [4:0]      cnt_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] direct_q;
  logic            direct_en_q;

  logic            is_m, start;
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, direct_hit;
  logic [XLEN-1:0] direct_val;
  logic [XLEN-1:0] core_result;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
`endif

  // Decode, operand magnitudes and special-case results.
  always_comb begin
    is_m     = ex_valid && (ex_opcode == OPC_OP) && (ex_func7 == F7_MULDIV);
    start    = (state_q == IDLE) && is_m && !kill;
    a_sgn    = rs1_signed(ex_func3);
    b_sgn    = rs2_signed(ex_func3);
    a_neg    = a_sgn && rs1_data[XLEN-1];
    b_neg    = b_sgn && rs2_data[XLEN-1];
    a_mag    = a_neg ? -rs1_data : rs1_data;
    b_mag    = b_neg ? -rs2_data : rs2_data;
    div_zero = ex_func3[2] && (rs2_data == '0);
    div_ovf  = ex_func3[2] && !ex_func3[0] && (rs1_data == INT_MIN) && (rs2_data == '1);
    direct_hit = div_zero || div_ovf;
    if (div_zero)
      direct_val = ex_func3[1] ? rs1_data : DIV0_Q;
    else
      direct_val = ex_func3[1] ? '0 : INT_MIN;
`ifdef MULDIV_FAST_MUL_EN
    fast_prod = {{XLEN{a_neg}}, rs1_data} * {{XLEN{b_neg}}, rs2_data};
    if (!ex_func3[2]) begin
      direct_hit = 1'b1;
      direct_val = (ex_func3 == F3_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif
  end

  // State register, step counter and captured rd / direct result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rd_q        <= '0;
      direct_q    <= '0;
      direct_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (kill) begin
        cnt_q       <= '0;
        direct_en_q <= 1'b0;
      end else if (start) begin
        cnt_q       <= '0;
        rd_q        <= ex_rd_addr;
        direct_q    <= direct_val;
        direct_en_q <= direct_hit;
      end else if (state_q == CALC) begin
        cnt_q <= cnt_q + 5'd1;
      end
    end
  end

  // Next state and outputs; kill overrides everything.
  always_comb begin
    state_d  = state_q;
    busy     = (state_q != IDLE);
    stall    = !rst && (start || (state_q == CALC));
    md_valid = (state_q == DONE) && !kill;
    unique case (state_q)
      IDLE: if (start) state_d = direct_hit ? DONE : CALC;
      CALC: if (cnt_q == 5'd31) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill) state_d = IDLE;
  end

  assign md_result  = md_valid ? (direct_en_q ? direct_q : core_result) : '0;
  assign md_rd_addr = rd_q;

  muldiv_core #(.XLEN(XLEN)) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (start),
    .step    ((state_q == CALC) && !kill),
    .func3   (ex_func3),
    .a_mag   (a_mag),
    .b_mag   (b_mag),
    .res_neg (a_neg ^ b_neg),
    .rem_neg (a_neg),
    .result  (core_result)
  );

endmodule
